// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: the buffered LU entry
// layout {pc, waddr, wdata} and its width.
package rf_arb_pkg;

    localparam int RF_ARB_ENTRY_WIDTH = 69;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_arb_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Small circular FIFO holding LU results awaiting the write port; exports each
// slot's destination and occupancy so the top can build the pending mask.
import rf_arb_pkg::*;

module rf_arb_fifo #(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        push,
    input  rf_arb_entry_t               push_entry,
    input  logic                        pop,
    output rf_arb_entry_t               head,
    output logic                        full,
    output logic                        empty,
    output logic [AW:0]                 count,
    output logic [DEPTH-1:0][4:0]       entry_waddr,
    output logic [DEPTH-1:0]            entry_valid
);

    rf_arb_entry_t   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Payload needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        entry_valid = '0;
        entry_waddr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_waddr[i] = mem[i].waddr;
            entry_valid[i] = ({1'b0, AW'(AW'(i) - rd_ptr)} < count);
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter between the WB stage and a buffered
// long-latency unit. Define RF_ARB_STARVE_EN to enable the WB-stall starvation guard.
import rf_arb_pkg::*;

module rf_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_pc,
    output logic        wb_stall,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    input  logic [31:0] lu_pc,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] pend_mask
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_param_err
        $error("rf_wport_arbiter: DEPTH must be a power of two >= 2, STARVE_MAX >= 1");
    end

    rf_arb_entry_t          fifo_head;
    rf_arb_entry_t          push_entry;
    rf_arb_entry_t          gnt;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [AW:0]            unused_fifo_count;
    logic [DEPTH-1:0][4:0]  entry_waddr;
    logic [DEPTH-1:0]       entry_valid;
    logic                   grant_lu;
    logic                   grant_wb;
    logic                   gnt_v;

    assign lu_ready   = resetn && !fifo_full;
    // r0 results are acknowledged but never stored.
    assign fifo_push  = lu_valid && lu_ready && (lu_waddr != 5'd0);
    assign push_entry = '{pc: lu_pc, waddr: lu_waddr, wdata: lu_wdata};

`ifdef RF_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (!resetn)                      starve_cnt <= '0;
        else if (fifo_empty || fifo_pop)  starve_cnt <= '0;
        else                              starve_cnt <= starve_cnt + 1'b1;
    end

    assign wb_stall = resetn && !fifo_empty && (starve_cnt == CW'(STARVE_MAX));
`else
    assign wb_stall = 1'b0;
`endif

    assign grant_lu = resetn && !fifo_empty && (wb_stall || !wb_we);
    assign grant_wb = resetn && !wb_stall && wb_we;
    assign fifo_pop = grant_lu;

    rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (fifo_push),
        .push_entry  (push_entry),
        .pop         (fifo_pop),
        .head        (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (unused_fifo_count),
        .entry_waddr (entry_waddr),
        .entry_valid (entry_valid)
    );

    always_comb begin
        gnt   = '0;
        gnt_v = 1'b0;
        if (grant_lu) begin
            gnt   = fifo_head;
            gnt_v = 1'b1;
        end else if (grant_wb) begin
            gnt   = '{pc: wb_pc, waddr: wb_waddr, wdata: wb_wdata};
            gnt_v = 1'b1;
        end
    end

    // A WB grant to r0 still owns the port this cycle; only the write is dropped.
    assign rf_we             = gnt_v && (gnt.waddr != 5'd0);
    assign rf_waddr          = gnt.waddr;
    assign rf_wdata          = gnt.wdata;
    assign debug_wb_pc       = gnt.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = gnt.waddr;
    assign debug_wb_rf_wdata = gnt.wdata;

    always_comb begin
        pend_mask = '0;
        if (resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_valid[i]) pend_mask[entry_waddr[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter (DEPTH=2, STARVE_MAX=4); covers both
// RF_ARB_STARVE_EN builds.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_pc;
    logic        wb_stall;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic [31:0] lu_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] pend_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .wb_we             (wb_we),
        .wb_waddr          (wb_waddr),
        .wb_wdata          (wb_wdata),
        .wb_pc             (wb_pc),
        .wb_stall          (wb_stall),
        .lu_valid          (lu_valid),
        .lu_ready          (lu_ready),
        .lu_waddr          (lu_waddr),
        .lu_wdata          (lu_wdata),
        .lu_pc             (lu_pc),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .pend_mask         (pend_mask)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs change just after the edge, checks at the negedge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        wb_we = we; wb_waddr = a; wb_wdata = d; wb_pc = pc;
    endtask

    task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        lu_valid = v; lu_waddr = a; lu_wdata = d; lu_pc = pc;
    endtask

    initial begin
        resetn = 1'b0;
        wb(1'b1, 5'd3, 32'h33, 32'h10);
        lu(1'b1, 5'd9, 32'h99, 32'h20);

        // Reset: requests present but everything quiet
        cyc(); cyc();
        settle();
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_stall", {31'd0, wb_stall}, 32'd0);
        chk("rst_dbg_we", {28'd0, debug_wb_rf_we}, 32'd0);
        cyc();
        resetn = 1'b1;
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        lu(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        chk("post_rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("post_rst_pend", pend_mask, 32'd0);

        // WB only
        cyc();
        wb(1'b1, 5'd5, 32'h1234, 32'h100);
        settle();
        chk("wb_rf_we", {31'd0, rf_we}, 32'd1);
        chk("wb_rf_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("wb_rf_wdata", rf_wdata, 32'h1234);
        chk("wb_dbg_we", {28'd0, debug_wb_rf_we}, 32'hF);
        chk("wb_dbg_pc", debug_wb_pc, 32'h100);
        chk("wb_dbg_wnum", {27'd0, debug_wb_rf_wnum}, 32'd5);

        // LU drain in WB-idle cycles, never same-cycle
        cyc();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        lu(1'b1, 5'd7, 32'hAA, 32'h200);
        settle();
        chk("lu_push_no_bypass", {31'd0, rf_we}, 32'd0);
        chk("lu_push_ready", {31'd0, lu_ready}, 32'd1);
        cyc();
        lu(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        chk("lu_pend7", pend_mask, 32'h80);
        chk("lu_rf_we", {31'd0, rf_we}, 32'd1);
        chk("lu_rf_waddr", {27'd0, rf_waddr}, 32'd7);
        chk("lu_rf_wdata", rf_wdata, 32'hAA);
        chk("lu_dbg_pc", debug_wb_pc, 32'h200);
        cyc();
        settle();
        chk("lu_pend_clr", pend_mask, 32'd0);
        chk("lu_idle_we", {31'd0, rf_we}, 32'd0);

        // LU push to r0 is discarded
        cyc();
        lu(1'b1, 5'd0, 32'h55, 32'h300);
        cyc();
        lu(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        chk("lu_r0_pend", pend_mask, 32'd0);
        chk("lu_r0_we", {31'd0, rf_we}, 32'd0);

        // WB to r0 keeps the slot; FIFO head is not popped
        cyc();
        wb(1'b1, 5'd0, 32'h77, 32'h400);
        lu(1'b1, 5'd4, 32'h44, 32'h404);
        cyc();
        lu(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        chk("wb_r0_we", {31'd0, rf_we}, 32'd0);
        chk("wb_r0_pend", pend_mask, 32'h10);
        cyc();
        settle();
        chk("wb_r0_no_pop", pend_mask, 32'h10);
        cyc();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        chk("r4_drain_waddr", {27'd0, rf_waddr}, 32'd4);
        chk("r4_drain_wdata", rf_wdata, 32'h44);
        cyc();
        settle();
        chk("r4_pend_clr", pend_mask, 32'd0);

        // Full/backpressure with WB busy
        cyc();
        wb(1'b1, 5'd5, 32'h5555, 32'h500);
        lu(1'b1, 5'd10, 32'hA0, 32'h510);
        settle();
        chk("full_rdy1", {31'd0, lu_ready}, 32'd1);
        cyc();
        lu(1'b1, 5'd11, 32'hB0, 32'h520);
        settle();
        chk("full_rdy2", {31'd0, lu_ready}, 32'd1);
        chk("full_wb_owns", {27'd0, rf_waddr}, 32'd5);
        cyc();
        lu(1'b1, 5'd12, 32'hC0, 32'h530);
        settle();
        chk("full_rdy3", {31'd0, lu_ready}, 32'd0);
        chk("full_pend", pend_mask, 32'h0C00);
        cyc();
        lu(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        chk("full_hold_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("full_hold_stall", {31'd0, wb_stall}, 32'd0);
        chk("full_hold_pend", pend_mask, 32'h0C00);
        cyc();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        chk("drain_first", {27'd0, rf_waddr}, 32'd10);
        chk("drain_first_d", rf_wdata, 32'hA0);
        cyc();
        settle();
        chk("drain_second", {27'd0, rf_waddr}, 32'd11);
        chk("drain_second_pend", pend_mask, 32'h0800);
        cyc();
        settle();
        chk("drain_done_we", {31'd0, rf_we}, 32'd0);
        chk("drain_done_pend", pend_mask, 32'd0);

        // Starvation guard (or its absence)
        cyc();
        wb(1'b1, 5'd6, 32'h66, 32'h600);
        lu(1'b1, 5'd20, 32'h20, 32'h610);
        cyc();
        lu(1'b0, 5'd0, 32'd0, 32'd0);
`ifdef RF_ARB_STARVE_EN
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk($sformatf("starve_wait%0d_stall", k), {31'd0, wb_stall}, 32'd0);
            chk($sformatf("starve_wait%0d_waddr", k), {27'd0, rf_waddr}, 32'd6);
            cyc();
        end
        settle();
        chk("starve_stall", {31'd0, wb_stall}, 32'd1);
        chk("starve_lu_waddr", {27'd0, rf_waddr}, 32'd20);
        chk("starve_lu_wdata", rf_wdata, 32'h20);
        cyc();
        settle();
        chk("starve_release", {31'd0, wb_stall}, 32'd0);
        chk("starve_wb_waddr", {27'd0, rf_waddr}, 32'd6);
        chk("starve_pend_clr", pend_mask, 32'd0);
        cyc();
        wb(1'b0, 5'd0, 32'd0, 32'd0);
`else
        for (int k = 1; k <= 6; k++) begin
            settle();
            chk($sformatf("nostarve%0d_stall", k), {31'd0, wb_stall}, 32'd0);
            chk($sformatf("nostarve%0d_waddr", k), {27'd0, rf_waddr}, 32'd6);
            cyc();
        end
        wb(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        chk("nostarve_drain", {27'd0, rf_waddr}, 32'd20);
        cyc();
`endif

        // Simultaneous push and pop preserve order
        lu(1'b1, 5'd1, 32'h1, 32'h700);
        cyc();
        lu(1'b1, 5'd2, 32'h2, 32'h704);
        settle();
        chk("pp_pop_r1", {27'd0, rf_waddr}, 32'd1);
        chk("pp_ready", {31'd0, lu_ready}, 32'd1);
        cyc();
        lu(1'b0, 5'd0, 32'd0, 32'd0);
        settle();
        chk("pp_pend_r2", pend_mask, 32'h4);
        chk("pp_pop_r2", {27'd0, rf_waddr}, 32'd2);
        cyc();
        settle();
        chk("pp_empty", {31'd0, rf_we}, 32'd0);

        // Reset mid-operation flushes the FIFO
        lu(1'b1, 5'd3, 32'h3, 32'h800);
        cyc();
        lu(1'b0, 5'd0, 32'd0, 32'd0);
        resetn = 1'b0;
        settle();
        chk("mrst_we", {31'd0, rf_we}, 32'd0);
        chk("mrst_pend", pend_mask, 32'd0);
        chk("mrst_ready", {31'd0, lu_ready}, 32'd0);
        cyc();
        resetn = 1'b1;
        settle();
        chk("mrst_flushed", pend_mask, 32'd0);
        chk("mrst_no_write", {31'd0, rf_we}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
